// File: rtl/dmux_pkg.sv
// Shared types for the stream demultiplexer: per-channel buffer state and counter width.
package dmux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } chan_state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/dmux_router_if.sv
// Producer-side stream plus per-channel consumer ports of the demultiplexer.
interface dmux_router_if #(
  parameter int WIDTH = 16,
  parameter int N_OUT = 4
);
  localparam int SEL_W = $clog2(N_OUT);

  logic [WIDTH-1:0]             data_in;
  logic [SEL_W-1:0]             sel_in;
  logic                         valid_in;
  logic                         ready_out;
  logic [N_OUT-1:0][WIDTH-1:0]  data_out;
  logic [N_OUT-1:0]             valid_out;
  logic [N_OUT-1:0]             ready_in;
  logic                         err_out;
  logic [dmux_pkg::CNT_W-1:0]   xfer_cnt_out;

  modport master (
    output data_in, sel_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, err_out, xfer_cnt_out
  );

  modport slave (
    input  data_in, sel_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, err_out, xfer_cnt_out
  );

endinterface

// File: rtl/dmux_chan_fifo.sv
// Two-entry per-channel buffer; a push is visible on head_o after the edge (pop possible next edge).
// Never pushed while FULL: the router holds its ready low for this channel.
module dmux_chan_fifo
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output chan_state_t      state_o
);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push_i) begin
          head_d  = din_i;
          state_d = ONE;
        end
      end
      ONE: begin
        // simultaneous push/pop keeps one word: the incoming word becomes the head
        if (push_i && pop_i) begin
          head_d = din_i;
        end else if (push_i) begin
          tail_d  = din_i;
          state_d = FULL;
        end else if (pop_i) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop_i) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign head_o  = head_q;
  assign state_o = state_q;

endmodule

// File: rtl/dmux_router.sv
// 1-to-N registered demux: word accepted at edge k is at its channel head after k; one word/cycle per channel.
// ready_out reflects only the selected channel's FULL state (never ready_in); out-of-range selects are dropped.
module dmux_router
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_OUT = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  dmux_router_if.slave bus
);

  localparam int SEL_W = $clog2(N_OUT);

  chan_state_t                 st_w [N_OUT];
  logic [N_OUT-1:0]            hit_w, full_w, valid_w, push_w, pop_w;
  logic [N_OUT-1:0][WIDTH-1:0] head_w;
  logic                        rdy_w, accept_w, drop_w;
  logic [CNT_W-1:0]            pops_w;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  always_comb begin
    hit_w = '0;
    for (int c = 0; c < N_OUT; c++) begin
      hit_w[c] = (bus.sel_in == SEL_W'(c));
    end
  end

  // no channel matched means the drop path, which is always ready
  always_comb begin
    rdy_w = 1'b1;
    for (int c = 0; c < N_OUT; c++) begin
      if (hit_w[c]) rdy_w = !full_w[c];
    end
  end

  assign accept_w = bus.valid_in && rdy_w;
  assign drop_w   = accept_w && !(|hit_w);
  assign push_w   = hit_w & {N_OUT{accept_w}};
  assign pop_w    = valid_w & bus.ready_in;

  for (genvar c = 0; c < N_OUT; c++) begin : g_chan
    dmux_chan_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .push_i  (push_w[c]),
      .pop_i   (pop_w[c]),
      .din_i   (bus.data_in),
      .head_o  (head_w[c]),
      .state_o (st_w[c])
    );
    assign full_w[c]  = (st_w[c] == FULL);
    assign valid_w[c] = (st_w[c] != EMPTY);
  end

  always_comb begin
    pops_w = '0;
    for (int c = 0; c < N_OUT; c++) begin
      pops_w = pops_w + CNT_W'(pop_w[c]);
    end
  end

  assign err_d = drop_w;
  assign cnt_d = cnt_q + pops_w;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ready_out    = rdy_w;
  assign bus.data_out     = head_w;
  assign bus.valid_out    = valid_w;
  assign bus.err_out      = err_q;
  assign bus.xfer_cnt_out = cnt_q;

endmodule
